// File: rtl/eq_word_sequencer.sv
// Word equality compare sequenced through one shared 4-bit EqCell,
// LSB nibble first, stopping at the first mismatching nibble.
module eq_word_sequencer #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [W-1:0]    a_in,
    input  logic [W-1:0]    b_in,
    output logic            busy,
    output logic            done,
    output logic            equal,
    output logic [IDXW-1:0] mismatch_idx,
    output logic [3:0]      cell_a,
    output logic [3:0]      cell_b,
    input  logic            cell_eq
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_reg_q, a_reg_d;
    logic [W-1:0]    b_reg_q, b_reg_d;
    logic            equal_q, equal_d;
    logic [IDXW-1:0] mis_q, mis_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        equal_d = equal_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort; abort alone does nothing here
                if (start) begin
                    a_reg_d = a_in;
                    b_reg_d = b_in;
                    idx_d   = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!cell_eq) begin
                    equal_d = 1'b0;
                    mis_d   = idx_q;
                    state_d = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    equal_d = 1'b1;
                    mis_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_reg_q <= '0;
            b_reg_q <= '0;
            equal_q <= 1'b0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            equal_q <= equal_d;
            mis_q   <= mis_d;
        end
    end

    // idx is not advanced on the way into DONE, so the same mux also holds the last pair
    always_comb begin
        cell_a = 4'h0;
        cell_b = 4'h0;
        if (state_q != S_IDLE) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == i[IDXW-1:0]) begin
                    cell_a = a_reg_q[4*i +: 4];
                    cell_b = b_reg_q[4*i +: 4];
                end
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign equal        = equal_q;
    assign mismatch_idx = mis_q;

endmodule

// File: tb/tb_eq_word_sequencer.sv
// Directed bench for eq_word_sequencer with a result scoreboard fed at start.
module tb_eq_word_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int IDXW    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic            busy;
    logic            done;
    logic            equal;
    logic [IDXW-1:0] mismatch_idx;
    logic [3:0]      cell_a;
    logic [3:0]      cell_b;
    logic            cell_eq;

    int errors = 0;
    int checks = 0;
    int ndone  = 0;
    logic [IDXW:0] sb[$];   // {equal, mismatch_idx}

    eq_word_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .equal(equal), .mismatch_idx(mismatch_idx),
        .cell_a(cell_a), .cell_b(cell_b), .cell_eq(cell_eq)
    );

    // the external EqCell
    assign cell_eq = (cell_a == cell_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            ndone++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [IDXW:0] e;
                e = sb.pop_front();
                chk("result", {equal, mismatch_idx}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive start so it is accepted on the next edge; returns 1ns after that edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, busy, 1'b0);
        tick();
        chk({tag, "_pending"}, sb.size(), 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_equal", equal, 0);
        chk("rst_midx", mismatch_idx, 0);
        chk("rst_cells", {cell_a, cell_b}, 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // full match, cell_a walks LSB nibble first
        sb.push_back({1'b1, 2'd0});
        issue(16'h1234, 16'h1234);
        chk("fm_busy", busy, 1);
        chk("fm_cell0", cell_a, 4'h4);
        tick(); chk("fm_cell1", cell_a, 4'h3);
        tick(); chk("fm_cell2", cell_a, 4'h2);
        tick(); chk("fm_cell3", cell_a, 4'h1);
        chk("fm_nodone_yet", done, 0);
        tick(); chk("fm_done", done, 1);
        chk("fm_hold", cell_a, 4'h1);
        tick(); chk("fm_busy_fall", busy, 0);
        chk("fm_cells_idle", {cell_a, cell_b}, 0);
        chk("fm_pending", sb.size(), 0);

        // mismatch on nibble 0: one CMP cycle
        sb.push_back({1'b0, 2'd0});
        issue(16'h1230, 16'h1234);
        tick(); chk("em_done", done, 1);
        finish_job("em");

        // mismatch on the last nibble, then a full match job
        sb.push_back({1'b0, 2'd3});
        issue(16'h5234, 16'h1234);
        finish_job("lm");
        sb.push_back({1'b1, 2'd0});
        issue(16'hFFFF, 16'hFFFF);
        tick();
        chk("lm_hold_eq", equal, 0);
        chk("lm_hold_idx", mismatch_idx, 3);
        finish_job("ff");

        // start while busy is ignored
        d0 = ndone;
        sb.push_back({1'b0, 2'd3});
        issue(16'h1234, 16'h2234);
        a_in = 16'hAAAA; b_in = 16'hAAAA; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        finish_job("busy");
        chk("busy_one_done", ndone - d0, 1);

        // abort sampled at T+3 returns to IDLE without done
        d0 = ndone;
        issue(16'h1234, 16'h1234);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", busy, 0);
        tick(); tick(); tick();
        chk("ab_no_done", ndone - d0, 0);
        chk("ab_equal", equal, 0);
        chk("ab_midx", mismatch_idx, 3);
        sb.push_back({1'b1, 2'd0});
        issue(16'h1234, 16'h1234);
        finish_job("ab_next");

        // abort while idle does nothing; start+abort in IDLE starts
        abort = 1'b1; tick();
        chk("ab_idle_ign", busy, 0);
        sb.push_back({1'b0, 2'd1});
        issue(16'h0010, 16'h0000);
        abort = 1'b0;
        chk("ab_start_wins", busy, 1);
        finish_job("sw");

        // async reset mid-compare
        sb.push_back({1'b1, 2'd0});
        issue(16'h1234, 16'h1234);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_equal", equal, 0);
        chk("ar_midx", mismatch_idx, 0);
        chk("ar_cells", {cell_a, cell_b}, 0);
        void'(sb.pop_back());
        d0 = ndone;
        tick(); tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("ar_no_done", ndone - d0, 0);
        chk("ar_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
